ocmem_rd_streamer: RTL and testbench
====================================

OCMEM_RD_STREAMER -- requirements
Module: ocmem_rd_streamer

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 32, memory word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, memory address width in bits.
REQ-003 SHALL have parameter LEN_WIDTH, default ADDR_WIDTH+1, transfer length width in bits.
REQ-004 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port start_i, input, 1, command strobe, sampled in IDLE only.
REQ-007 SHALL have port base_i, input, ADDR_WIDTH, first word address, sampled with start_i.
REQ-008 SHALL have port len_i, input, LEN_WIDTH, word count, sampled with start_i.
REQ-009 SHALL have port abort_i, input, 1, cancels the active transfer.
REQ-010 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-011 SHALL have port done_o, output, 1, one-cycle pulse on normal completion.
REQ-012 SHALL have port mem_ce_o, output, 1, memory chip enable.
REQ-013 SHALL have port mem_addr_o, output, ADDR_WIDTH, memory address.
REQ-014 SHALL have port mem_we_o, output, 1, memory write enable; constant 0.
REQ-015 SHALL have port mem_d_o, output, MEM_WIDTH, memory write data; constant 0.
REQ-016 SHALL have port mem_q_i, input, MEM_WIDTH, read data, valid one cycle after mem_ce_o.
REQ-017 SHALL have port m_valid_o, output, 1, stream data valid.
REQ-018 SHALL have port m_data_o, output, MEM_WIDTH, stream data.
REQ-019 SHALL have port m_ready_i, input, 1, stream sink ready.

Function
REQ-020 SHALL implement states IDLE, RUN and DRAIN.
REQ-021 IDLE->RUN SHALL occur on start_i with len_i!=0; start_i with len_i==0 SHALL stay in IDLE, issue no reads, and pulse done_o the next cycle.
REQ-022 start_i outside IDLE SHALL be ignored.
REQ-023 The first mem_ce_o SHALL be asserted the cycle after start_i with mem_addr_o=base_i; the first m_valid_o SHALL assert the cycle after that.
REQ-024 Read n SHALL use address (base+n) mod 2**ADDR_WIDTH; the address wraps with no error.
REQ-025 A 2-entry output buffer SHALL absorb the 1-cycle read latency; a read SHALL be issued only if buffered words plus in-flight words < 2.
REQ-026 With m_ready_i held high, throughput SHALL be one word per cycle with no bubbles after the first word.
REQ-027 m_valid_o/m_data_o SHALL stay stable while m_valid_o=1 and m_ready_i=0; words SHALL leave in address order with none lost or duplicated.
REQ-028 RUN->DRAIN SHALL occur when the last read is issued; DRAIN->IDLE SHALL occur on the last handshake, with done_o pulsing in the following cycle.
REQ-029 abort_i in RUN or DRAIN SHALL force IDLE the next cycle, flush the buffer, drop in-flight data, deassert m_valid_o and mem_ce_o, and suppress done_o.
REQ-030 Maximum supported len_i SHALL be 2**ADDR_WIDTH.

Reset
REQ-031 Asserting rst_ni low SHALL immediately force IDLE and set busy_o, done_o, mem_ce_o, m_valid_o=0, and mem_addr_o, m_data_o=0.
REQ-032 Reset mid-transfer SHALL discard all state; after release the block SHALL accept start_i in the first clock cycle.

Configuration
REQ-033 Macro OCMEM_RD_LOOP_EN SHALL add input loop_i (1 bit, sampled with start_i).
REQ-034 With the macro defined and loop_i=1, the block SHALL, after word len-1, continue reading at base again, never enter DRAIN, never pulse done_o, and stop only on abort_i or reset.
REQ-035 Without the macro, loop_i SHALL not exist and behaviour SHALL be as in REQ-020..030.

Structure
REQ-036 State encoding and the buffer depth constant (2) SHALL reside in shared package ocmem_pkg.
REQ-037 The output buffer SHALL be the sub-module ocmem_skid_buf; the FSM and address counter SHALL stay in the top module.

Verification
REQ-038 base=0x010, len=4, ready=1 -> ce at cycles 1-4 with addr 0x010-0x013, valid at cycles 2-5 with data mem[0x010..0x013], done pulse at cycle 6.
REQ-039 base=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 in order.
REQ-040 len=8, ready toggling 1,0,0,1 -> all 8 words delivered in order, data stable while stalled, at most 2 outstanding reads.
REQ-041 len=0 -> no ce, no valid, done pulse 1 cycle after start.
REQ-042 abort_i at third beat of len=16 -> IDLE next cycle, valid=0, no done; new start then streams correctly from its base.
REQ-043 With OCMEM_RD_LOOP_EN, base=0x020, len=3, loop=1 -> repeating addresses 0x020, 0x021, 0x022, 0x020 ... with no done; abort stops it.

Source files
------------

// File: rtl/ocmem_pkg.sv
// ocmem_pkg: shared FSM state encoding and output buffer depth for the on-chip memory read streamer.
package ocmem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/ocmem_skid_buf.sv
// ocmem_skid_buf: 2-entry fall-through buffer absorbing the 1-cycle memory read latency.
// Ports: clk_i/rst_ni clock and async active-low reset; i_flush drops buffered and in-flight words;
// i_issue marks a read issued this cycle; i_mem_q read data; i_ready sink ready;
// o_valid/o_data stream output; o_can_issue a read may be issued this cycle; o_last final word leaves now.
module ocmem_skid_buf
  import ocmem_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_flush,
  input  logic         i_issue,
  input  logic [W-1:0] i_mem_q,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_can_issue,
  output logic         o_last
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [W-1:0]  r_mem [BUF_DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt, w_lvl;
  logic          r_infl, w_pop, w_pop_buf, w_push;
  // An empty buffer lets the returning word straight through, so the first beat costs no extra cycle.
  assign o_valid     = (r_cnt != '0) || r_infl;
  assign o_data      = (r_cnt != '0) ? r_mem[r_rd] : (r_infl ? i_mem_q : '0);
  assign w_pop       = o_valid && i_ready;
  assign w_pop_buf   = w_pop && (r_cnt != '0);
  assign w_push      = r_infl && !(w_pop && (r_cnt == '0));
  assign w_lvl       = r_cnt + CW'(r_infl);
  // Counting the word leaving this cycle keeps full throughput with ready held high.
  assign o_can_issue = (w_lvl - CW'(w_pop)) < CW'(BUF_DEPTH);
  assign o_last      = w_pop && (w_lvl == CW'(1));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_infl <= 1'b0;
    end else if (i_flush) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_infl <= 1'b0;
    end else begin
      r_infl <= i_issue;
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop_buf) r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop_buf);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= i_mem_q;
  end
endmodule

// File: rtl/ocmem_rd_streamer.sv
// ocmem_rd_streamer: streams len words from an on-chip memory starting at base, wrapping the address.
// Ports: clk_i, rst_ni (async active-low); start_i/base_i/len_i command; abort_i cancel;
// busy_o/done_o status; mem_ce_o/mem_addr_o/mem_we_o/mem_d_o/mem_q_i memory side;
// m_valid_o/m_data_o/m_ready_i stream side. Macro OCMEM_RD_LOOP_EN adds loop_i for endless re-reading.
module ocmem_rd_streamer
  import ocmem_pkg::*;
#(
  parameter int MEM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
`ifdef OCMEM_RD_LOOP_EN
  input  logic                  loop_i,
`endif
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_ce_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [MEM_WIDTH-1:0]  mem_d_o,
  input  logic [MEM_WIDTH-1:0]  mem_q_i,
  output logic                  m_valid_o,
  output logic [MEM_WIDTH-1:0]  m_data_o,
  input  logic                  m_ready_i
);
  state_e                r_state, w_state_n;
  logic [ADDR_WIDTH-1:0] r_addr, r_base;
  logic [LEN_WIDTH-1:0]  r_rem, r_len;
  logic                  r_done, w_done_n, w_loop, w_can_issue, w_last, w_start, w_flush, w_wrap;
`ifdef OCMEM_RD_LOOP_EN
  logic                  r_loop;
  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif
  assign busy_o     = r_state != ST_IDLE;
  assign done_o     = r_done;
  assign mem_addr_o = r_addr;
  assign mem_we_o   = 1'b0;
  assign mem_d_o    = '0;
  assign w_start    = (r_state == ST_IDLE) && start_i && (len_i != '0);
  assign w_flush    = abort_i && busy_o;
  assign w_wrap     = r_rem == LEN_WIDTH'(1);
  assign mem_ce_o   = (r_state == ST_RUN) && !abort_i && w_can_issue;
  ocmem_skid_buf #(.W(MEM_WIDTH)) u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_flush     (w_flush),
    .i_issue     (mem_ce_o),
    .i_mem_q     (mem_q_i),
    .i_ready     (m_ready_i),
    .o_valid     (m_valid_o),
    .o_data      (m_data_o),
    .o_can_issue (w_can_issue),
    .o_last      (w_last)
  );
  always_comb begin
    w_state_n = r_state;
    w_done_n  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_n = w_start ? ST_RUN : ST_IDLE;
        w_done_n  = start_i && (len_i == '0);
      end
      ST_RUN: w_state_n = abort_i ? ST_IDLE : (mem_ce_o && w_wrap && !w_loop) ? ST_DRAIN : ST_RUN;
      ST_DRAIN: begin
        w_state_n = (abort_i || w_last) ? ST_IDLE : ST_DRAIN;
        w_done_n  = !abort_i && w_last;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_base  <= '0;
      r_rem   <= '0;
      r_len   <= '0;
`ifdef OCMEM_RD_LOOP_EN
      r_loop  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_done  <= w_done_n;
      if (w_start) begin
        r_addr <= base_i;
        r_base <= base_i;
        r_rem  <= len_i;
        r_len  <= len_i;
`ifdef OCMEM_RD_LOOP_EN
        r_loop <= loop_i;
`endif
      end else if (mem_ce_o) begin
        // In loop mode the last read of a pass restarts the counters at base.
        r_addr <= (w_wrap && w_loop) ? r_base : r_addr + ADDR_WIDTH'(1);
        r_rem  <= (w_wrap && w_loop) ? r_len : r_rem - LEN_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_ocmem_rd_streamer.sv
// tb_ocmem_rd_streamer: table-driven scoreboard bench for ocmem_rd_streamer.
module tb_ocmem_rd_streamer;
  typedef struct {
    logic [9:0]  base;
    logic [10:0] len;
    logic [3:0]  rdy;
    int          lat;
    bit          poke;
  } vec_t;
  logic        clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, abort_i = 1'b0, m_ready_i = 1'b1;
  logic [9:0]  base_i = '0;
  logic [10:0] len_i = '0;
  logic        busy_o, done_o, mem_ce_o, mem_we_o, m_valid_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_d_o, m_data_o, mem_q_i = '0;
`ifdef OCMEM_RD_LOOP_EN
  logic        loop_i = 1'b0;
`endif
  int checks = 0, errors = 0, cyc = 0, start_cyc = 0;
  int n_iss, n_pop, done_cnt, done_cyc, first_ce, first_v, last_v;
  bit mon_en = 1'b0, prev_stall = 1'b0, skip = 1'b0;
  logic [31:0] prev_data = '0;
  logic        ce_q = 1'b0;
  logic [9:0]  a_q = '0;
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  vec_t vecs[9];

  ocmem_rd_streamer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_i(base_i), .len_i(len_i),
`ifdef OCMEM_RD_LOOP_EN
    .loop_i(loop_i),
`endif
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .mem_ce_o(mem_ce_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {6'h2A, a, ~a, 6'h15};
  endfunction

  // Memory model: data for the address seen with ce appears one cycle later, junk otherwise.
  always @(negedge clk_i) begin
    ce_q <= mem_ce_o;
    a_q  <= mem_addr_o;
  end
  always @(posedge clk_i) mem_q_i <= ce_q ? mem_word(a_q) : 32'hDEADBEEF;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && mon_en) begin
      if (mem_ce_o) begin
        n_iss++;
        if (first_ce < 0) first_ce = cyc - start_cyc;
        if (exp_addr.size() == 0) check("ce_unexpected", 1, 0);
        else check("ce_addr", 64'(mem_addr_o), 64'(exp_addr.pop_front()));
      end
      if (m_valid_o) begin
        if (first_v < 0) first_v = cyc - start_cyc;
        last_v = cyc - start_cyc;
      end
      if (!skip && prev_stall) begin
        check("stall_valid", 64'(m_valid_o), 1);
        check("stall_data", 64'(m_data_o), 64'(prev_data));
      end
      if (m_valid_o && m_ready_i) begin
        n_pop++;
        if (exp_data.size() == 0) check("beat_unexpected", 1, 0);
        else check("beat_data", 64'(m_data_o), 64'(exp_data.pop_front()));
      end
      if (mem_ce_o) check("outstanding_le2", 64'((n_iss - n_pop) <= 2), 1);
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc - start_cyc;
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      skip       = 1'b0;
    end
  end

  task automatic arm(input logic [9:0] base, input int n);
    exp_addr.delete();
    exp_data.delete();
    n_iss = 0; n_pop = 0; done_cnt = 0; done_cyc = -1;
    first_ce = -1; first_v = -1; last_v = -1;
    prev_stall = 1'b0; skip = 1'b1;
    start_cyc = cyc;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(base + 10'(k));
      exp_data.push_back(mem_word(base + 10'(k)));
    end
  endtask

  // Called right after a rising edge; cycle 0 is the cycle start_i is high.
  task automatic run_vec(input vec_t v);
    int budget;
    budget = int'(v.len) * 8 + 20;
    arm(v.base, int'(v.len));
    start_i = 1'b1; base_i = v.base; len_i = v.len; m_ready_i = v.rdy[0];
    for (int t = 1; t <= budget; t++) begin
      @(posedge clk_i); #1;
      start_i = v.poke && (t == 2);
      base_i  = 10'h2AA;
      len_i   = 11'd1;
      m_ready_i = v.rdy[t % 4];
      if (t == 1 && v.len != 0) check("busy_run", 64'(busy_o), 1);
      if (done_cnt != 0 && (cyc - start_cyc) >= done_cyc + 2) break;
    end
    check("done_once", 64'(done_cnt), 1);
    check("scoreboard_empty", 64'(exp_addr.size() + exp_data.size()), 0);
    check("idle_after", 64'(busy_o), 0);
    if (v.lat != 0) begin
      check("done_latency", 64'(done_cyc), 64'(v.lat));
      if (v.len == 0) check("no_activity", 64'({first_ce, first_v}), {32'hFFFFFFFF, 32'hFFFFFFFF});
      else begin
        check("first_ce_cycle", 64'(first_ce), 1);
        check("first_valid_cycle", 64'(first_v), 2);
        check("no_bubbles", 64'(last_v - first_v + 1), 64'(v.len));
      end
    end
    m_ready_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{10'h010, 11'd4,    4'b1111, 6,    1'b0};
    vecs[1] = '{10'h3FE, 11'd4,    4'b1111, 6,    1'b0};
    vecs[2] = '{10'h000, 11'd8,    4'b1001, 0,    1'b0};
    vecs[3] = '{10'h000, 11'd0,    4'b1111, 1,    1'b0};
    vecs[4] = '{10'h123, 11'd1,    4'b1111, 3,    1'b0};
    vecs[5] = '{10'h200, 11'd5,    4'b0101, 0,    1'b1};
    vecs[6] = '{10'h3FF, 11'd2,    4'b1111, 4,    1'b0};
    vecs[7] = '{10'h050, 11'd3,    4'b0001, 0,    1'b1};
    vecs[8] = '{10'h100, 11'd1024, 4'b1111, 1026, 1'b0};
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_outputs", 64'({busy_o, done_o, mem_ce_o, m_valid_o, mem_addr_o, m_data_o}), 0);
    check("we_d_const", 64'({mem_we_o, mem_d_o}), 0);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Abort on the third beat of a 16-word transfer.
    arm(10'h080, 16);
    start_i = 1'b1; base_i = 10'h080; len_i = 11'd16; m_ready_i = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      abort_i = (t == 4);
      if (t == 5) begin
        check("abort_busy", 64'(busy_o), 0);
        check("abort_valid_ce", 64'({m_valid_o, mem_ce_o}), 0);
      end
    end
    check("abort_beats", 64'(n_pop), 3);
    check("abort_no_done", 64'(done_cnt), 0);
    run_vec('{10'h3F0, 11'd3, 4'b1111, 5, 1'b0});

    // Reset in the middle of a stalled transfer, then start in the first cycle after release.
    arm(10'h300, 10);
    start_i = 1'b1; base_i = 10'h300; len_i = 11'd10; m_ready_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    #2 rst_ni = 1'b0;
    mon_en = 1'b0;
    #1;
    check("async_rst_outputs", 64'({busy_o, done_o, mem_ce_o, m_valid_o, mem_addr_o, m_data_o}), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;
    run_vec('{10'h3FD, 11'd6, 4'b1111, 8, 1'b0});

`ifdef OCMEM_RD_LOOP_EN
    arm(10'h020, 0);
    for (int k = 0; k < 12; k++) begin
      exp_addr.push_back(10'h020 + 10'(k % 3));
      exp_data.push_back(mem_word(10'h020 + 10'(k % 3)));
    end
    start_i = 1'b1; base_i = 10'h020; len_i = 11'd3; loop_i = 1'b1; m_ready_i = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      loop_i  = 1'b0;
      abort_i = (t == 10);
      if (t == 9) check("loop_busy", 64'(busy_o), 1);
    end
    check("loop_reads", 64'(n_iss), 9);
    check("loop_no_done", 64'(done_cnt), 0);
    check("loop_stopped", 64'(busy_o), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
